// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
// The request fields are held stable from the first request cycle through the ack cycle.
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM stage: non-memory and misaligned ops produce a write-back record 1 cycle later; loads and stores do so 1 cycle after dmem ack.
// Holds upstream with stall for the whole bus access; aborts with bus_err after TIMEOUT cycles without ack (0 = wait forever).
module mem_stage #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] pc,
   input  logic [31:0] result,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   input  logic [3:0]  msg,
   input  logic [4:0]  ctl,
   output logic        stall,
   mem_stage_if.master dmem,
   output logic        wb_valid,
   output logic [31:0] wb_pc,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_we,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] pc_l_q, pc_l_d;
   logic [4:0]  rd_l_q, rd_l_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  lane_q, lane_d;
   logic        rw_q, rw_d;
   logic        wb_valid_q, wb_valid_d;
   logic [31:0] wb_pc_q, wb_pc_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_we_q, wb_we_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic [31:0] st_wdata;
   logic [3:0]  st_be;
   logic        is_mem;
   logic        mis;
   logic        timeout_hit;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        unused_ok;

   assign unused_ok = ^{msg[3], ctl[4:3]};

   assign is_mem      = ctl[1] | ctl[2];
   // funct3[1:0]: 00 byte, 01 half, 1x word
   assign mis         = ((msg[1:0] == 2'b01) && result[0]) ||
                        (msg[1] && (result[1:0] != 2'b00));
   assign timeout_hit = (TIMEOUT != 8'd0) && ((cnt_q + 8'd1) == TIMEOUT);

   always_comb begin
      st_wdata = store_data;
      st_be    = 4'b1111;
      case (msg[1:0])
         2'b00: begin
            st_wdata = {4{store_data[7:0]}};
            st_be    = 4'b0001 << result[1:0];
         end
         2'b01: begin
            st_wdata = {2{store_data[15:0]}};
            st_be    = 4'b0011 << result[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = dmem.rdata[7:0];
      case (lane_q)
         2'b01:   ld_byte = dmem.rdata[15:8];
         2'b10:   ld_byte = dmem.rdata[23:16];
         2'b11:   ld_byte = dmem.rdata[31:24];
         default: ld_byte = dmem.rdata[7:0];
      endcase
      ld_half = lane_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = dmem.rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      pc_l_d     = pc_l_q;
      rd_l_d     = rd_l_q;
      f3_d       = f3_q;
      lane_d     = lane_q;
      rw_d       = rw_q;
      wb_valid_d = 1'b0;
      wb_pc_d    = wb_pc_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_we_d    = wb_we_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!is_mem || mis) begin
                  wb_valid_d = 1'b1;
                  wb_pc_d    = pc;
                  wb_rd_d    = rd;
                  wb_data_d  = result;
                  wb_we_d    = !is_mem && ctl[0] && (rd != 5'd0);
                  misalign_d = is_mem;
               end else begin
                  state_d = BUS;
                  cnt_d   = 8'd0;
                  pc_l_d  = pc;
                  rd_l_d  = rd;
                  f3_d    = msg[2:0];
                  lane_d  = result[1:0];
                  rw_d    = ctl[0];
                  we_d    = ctl[2];
                  addr_d  = {result[31:2], 2'b00};
                  wdata_d = st_wdata;
                  be_d    = st_be;
               end
            end
         end
         BUS: begin
            cnt_d = cnt_q + 8'd1;
            if (dmem.ack || timeout_hit) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_pc_d    = pc_l_q;
               wb_rd_d    = rd_l_q;
               wb_data_d  = {addr_q[31:2], lane_q};
               wb_we_d    = 1'b0;
               // ack wins over a timeout landing in the same cycle
               if (dmem.ack) begin
                  if (!we_q) begin
                     wb_data_d = ld_data;
                     wb_we_d   = rw_q && (rd_l_q != 5'd0);
                  end
               end else begin
                  bus_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         pc_l_q     <= 32'd0;
         rd_l_q     <= 5'd0;
         f3_q       <= 3'd0;
         lane_q     <= 2'd0;
         rw_q       <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_pc_q    <= 32'd0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_we_q    <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         pc_l_q     <= pc_l_d;
         rd_l_q     <= rd_l_d;
         f3_q       <= f3_d;
         lane_q     <= lane_d;
         rw_q       <= rw_d;
         wb_valid_q <= wb_valid_d;
         wb_pc_q    <= wb_pc_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_we_q    <= wb_we_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign stall      = (state_q == BUS);
   assign dmem.req   = (state_q == BUS);
   assign dmem.we    = we_q;
   assign dmem.addr  = addr_q;
   assign dmem.wdata = wdata_q;
   assign dmem.be    = be_q;
   assign wb_valid   = wb_valid_q;
   assign wb_pc      = wb_pc_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign wb_we      = wb_we_q;
   assign misalign   = misalign_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected write-back records, a negedge monitor pops and compares them.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] pc, result, store_data;
   logic [4:0]  rd;
   logic [3:0]  msg;
   logic [4:0]  ctl;
   logic        stall, wb_valid, wb_we, misalign, bus_err;
   logic [31:0] wb_pc, wb_data;
   logic [4:0]  wb_rd;

   mem_stage_if dif();

   mem_stage #(.TIMEOUT(8'd4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc(pc), .result(result),
      .store_data(store_data), .rd(rd), .msg(msg), .ctl(ctl), .stall(stall),
      .dmem(dif), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_we(wb_we), .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        mis;
      logic        berr;
      logic        chk_data;
      int          at;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (wb_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wb_unexpected: got wb_valid pc=%h expected none", wb_pc);
            end else begin
               mon_e = q.pop_front();
               check("wb_cycle", cyc, mon_e.at);
               check("wb_pc", wb_pc, mon_e.pc);
               check("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
               check("wb_we", {31'd0, wb_we}, {31'd0, mon_e.we});
               check("wb_misalign", {31'd0, misalign}, {31'd0, mon_e.mis});
               check("wb_bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
               if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
            end
         end else begin
            check("pulse_idle", {30'd0, misalign, bus_err}, 32'd0);
         end
      end
   end

   task automatic drive(input logic [31:0] p, input logic [31:0] r, input logic [31:0] s,
                        input logic [4:0] d, input logic [3:0] m, input logic [4:0] c);
      in_valid = 1'b1; pc = p; result = r; store_data = s; rd = d; msg = m; ctl = c;
   endtask

   task automatic expect_wb(input logic [31:0] p, input logic [4:0] d, input logic [31:0] data,
                            input logic we, input logic mis, input logic berr,
                            input logic chk_data, input int at);
      exp_t e;
      e.pc = p; e.rd = d; e.data = data; e.we = we; e.mis = mis; e.berr = berr;
      e.chk_data = chk_data; e.at = at;
      q.push_back(e);
   endtask

   task automatic accept();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Runs 12 cycles after acceptance; ack_at = BUS cycle (1-based) carrying the ack, 0 = never.
   task automatic run_bus(input int ack_at, input logic [31:0] word,
                          output int req_cnt, output int stall_cnt,
                          output logic [31:0] f_addr, output logic [31:0] f_wdata,
                          output logic [3:0] f_be, output logic f_we);
      req_cnt = 0; stall_cnt = 0;
      f_addr = 32'd0; f_wdata = 32'd0; f_be = 4'd0; f_we = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c == ack_at) begin
            dif.ack = 1'b1;
            dif.rdata = word;
         end
         @(negedge clk);
         if (c == 1) begin
            f_addr = dif.addr; f_wdata = dif.wdata; f_be = dif.be; f_we = dif.we;
         end
         if (dif.req) req_cnt++;
         if (stall) stall_cnt++;
         @(posedge clk); #1;
         dif.ack = 1'b0;
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] pc, res, sd;
      logic [4:0]  rd;
      logic [3:0]  msg;
      logic [4:0]  ctl;
      int          ack_at;     // 0: no bus access expected
      logic [31:0] rdata;
      logic [31:0] exp_data;
      logic        exp_we, exp_mis, exp_berr, chk_data;
      int          lat;
      int          exp_req;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_be;
      logic        exp_dwe;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string n, logic [31:0] p, logic [31:0] r, logic [31:0] s,
                               logic [4:0] d, logic [3:0] m, logic [4:0] c, int ack_at,
                               logic [31:0] rdw, logic [31:0] ed, logic ew, logic em,
                               logic eb, logic cd, int lat, int ereq, logic [31:0] ea,
                               logic [31:0] ewd, logic [3:0] ebe, logic edwe);
      vec_t v;
      v.name = n; v.pc = p; v.res = r; v.sd = s; v.rd = d; v.msg = m; v.ctl = c;
      v.ack_at = ack_at; v.rdata = rdw; v.exp_data = ed; v.exp_we = ew; v.exp_mis = em;
      v.exp_berr = eb; v.chk_data = cd; v.lat = lat; v.exp_req = ereq; v.exp_addr = ea;
      v.exp_wdata = ewd; v.exp_be = ebe; v.exp_dwe = edwe;
      return v;
   endfunction

   int          rq, sc, c0;
   logic [31:0] fa, fw;
   logic [3:0]  fb;
   logic        fwe;

   initial begin
      rst = 1'b0; in_valid = 1'b0; pc = 0; result = 0; store_data = 0; rd = 0; msg = 0; ctl = 0;
      dif.ack = 1'b0; dif.rdata = 32'd0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_req", {31'd0, dif.req}, 32'd0);
      check("rst_dwe", {31'd0, dif.we}, 32'd0);
      check("rst_addr", dif.addr, 32'd0);
      check("rst_wdata", dif.wdata, 32'd0);
      check("rst_be", {28'd0, dif.be}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_pc", wb_pc, 32'd0);
      check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_flags", {29'd0, wb_we, misalign, bus_err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      //            name   pc        result    store_data rd  msg   ctl       ack rdata      exp_data   we mis be cd lat req addr      wdata      be       dwe
      vecs.push_back(mk("alu",  32'h1000, 32'h1234, 32'h0, 5'd5, 4'h0, 5'b00001, 0, 32'h0, 32'h1234, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0));
      vecs.push_back(mk("lb",   32'h1004, 32'h103, 32'h0, 5'd6, 4'h0, 5'b00011, 3, 32'h80AABBCC, 32'hFFFFFF80, 1, 0, 0, 1, 3, 3, 32'h100, 32'h0, 4'b1000, 0));
      vecs.push_back(mk("lbu",  32'h1008, 32'h103, 32'h0, 5'd7, 4'h4, 5'b00011, 3, 32'h80AABBCC, 32'h00000080, 1, 0, 0, 1, 3, 3, 32'h100, 32'h0, 4'b1000, 0));
      vecs.push_back(mk("sh",   32'h100C, 32'h202, 32'hDEADBEEF, 5'd0, 4'h1, 5'b00100, 1, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1, 32'h200, 32'hBEEFBEEF, 4'b1100, 1));
      vecs.push_back(mk("lw_mis", 32'h1010, 32'h101, 32'h0, 5'd8, 4'h2, 5'b00011, 0, 32'h0, 32'h101, 0, 1, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0));
      vecs.push_back(mk("lh",   32'h1018, 32'h402, 32'h0, 5'd10, 4'h1, 5'b00011, 2, 32'h80011234, 32'hFFFF8001, 1, 0, 0, 1, 2, 2, 32'h400, 32'h0, 4'b1100, 0));
      vecs.push_back(mk("lhu",  32'h101C, 32'h400, 32'h0, 5'd12, 4'h5, 5'b00011, 2, 32'h1234F00D, 32'h0000F00D, 1, 0, 0, 1, 2, 2, 32'h400, 32'h0, 4'b0011, 0));
      vecs.push_back(mk("lb_pos", 32'h1020, 32'h401, 32'h0, 5'd13, 4'h0, 5'b00011, 1, 32'h12345678, 32'h00000056, 1, 0, 0, 1, 1, 1, 32'h400, 32'h0, 4'b0010, 0));
      vecs.push_back(mk("sb",   32'h1024, 32'h301, 32'h000000A5, 5'd0, 4'h0, 5'b00100, 2, 32'h0, 32'h0, 0, 0, 0, 0, 2, 2, 32'h300, 32'hA5A5A5A5, 4'b0010, 1));
      vecs.push_back(mk("sh_mis", 32'h1028, 32'h203, 32'h0, 5'd0, 4'h1, 5'b00100, 0, 32'h0, 32'h203, 0, 1, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0));
      vecs.push_back(mk("lw_to", 32'h1014, 32'h400, 32'h0, 5'd9, 4'h2, 5'b00011, 7, 32'h0, 32'h0, 0, 0, 1, 0, 4, 4, 32'h400, 32'h0, 4'b1111, 0));

      foreach (vecs[i]) begin
         c0 = cyc;
         drive(vecs[i].pc, vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].msg, vecs[i].ctl);
         expect_wb(vecs[i].pc, vecs[i].rd, vecs[i].exp_data, vecs[i].exp_we, vecs[i].exp_mis,
                   vecs[i].exp_berr, vecs[i].chk_data, c0 + 1 + vecs[i].lat);
         accept();
         run_bus(vecs[i].ack_at, vecs[i].rdata, rq, sc, fa, fw, fb, fwe);
         check({vecs[i].name, "_req_cycles"}, rq, vecs[i].exp_req);
         check({vecs[i].name, "_stall_cycles"}, sc, vecs[i].exp_req);
         if (vecs[i].exp_req != 0) begin
            check({vecs[i].name, "_addr"}, fa, vecs[i].exp_addr);
            check({vecs[i].name, "_be"}, {28'd0, fb}, {28'd0, vecs[i].exp_be});
            check({vecs[i].name, "_dmem_we"}, {31'd0, fwe}, {31'd0, vecs[i].exp_dwe});
            if (vecs[i].exp_dwe) check({vecs[i].name, "_wdata"}, fw, vecs[i].exp_wdata);
         end
      end

      // wb fields hold between pulses (last record was the timeout on pc 0x1014)
      @(negedge clk);
      check("hold_valid", {31'd0, wb_valid}, 32'd0);
      check("hold_pc", wb_pc, 32'h1014);

      // SW with both read and write set, next ALU op held under stall
      @(posedge clk); #1;
      c0 = cyc;
      drive(32'h2000, 32'h300, 32'h11223344, 5'd3, 4'h2, 5'b00110);
      expect_wb(32'h2000, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, c0 + 3);
      @(posedge clk); #1;
      drive(32'h2004, 32'hABCD, 32'h0, 5'd4, 4'h0, 5'b00001);
      expect_wb(32'h2004, 5'd4, 32'hABCD, 1'b1, 1'b0, 1'b0, 1'b1, c0 + 4);
      @(posedge clk); #1;
      dif.ack = 1'b1;
      @(negedge clk);
      check("b2b_addr", dif.addr, 32'h300);
      check("b2b_dmem_we", {31'd0, dif.we}, 32'd1);
      check("b2b_wdata", dif.wdata, 32'h11223344);
      check("b2b_be", {28'd0, dif.be}, 32'hF);
      @(posedge clk); #1;
      dif.ack = 1'b0;
      accept();
      repeat (4) @(posedge clk);
      #1;

      // reset in the middle of a bus access
      drive(32'h3000, 32'h500, 32'h0, 5'd11, 4'h2, 5'b00011);
      accept();
      @(negedge clk);
      check("rstmid_req_before", {31'd0, dif.req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rstmid_req", {31'd0, dif.req}, 32'd0);
      check("rstmid_stall", {31'd0, stall}, 32'd0);
      check("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // LW to x0 after reset release
      c0 = cyc;
      drive(32'h3004, 32'h40, 32'h0, 5'd0, 4'h2, 5'b00011);
      expect_wb(32'h3004, 5'd0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b1, c0 + 3);
      accept();
      run_bus(2, 32'hCAFEF00D, rq, sc, fa, fw, fb, fwe);
      check("lw_x0_req_cycles", rq, 2);
      check("lw_x0_addr", fa, 32'h40);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000");
      $fatal(1);
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V core, on the consuming side of the EX/MEM pipeline register. It takes the registered EX/MEM fields and performs loads and stores over a req/ack data-memory bus. It holds the pipeline via `stall` while an access is outstanding and presents one registered write-back record per instruction toward MEM/WB. Non-memory instructions pass through in one cycle.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `dmem_ack` before aborting (8-bit counter; 0 disables the timeout).

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: EX/MEM holds a valid instruction.
- `pc` in 32: instruction PC.
- `result` in 32: ALU result; this is the effective address for memory operations.
- `store_data` in 32: rs2 value for stores.
- `rd` in 5: destination register.
- `msg` in 4: [2:0] funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU); [3] reserved.
- `ctl` in 5: [0] reg_write, [1] mem_read, [2] mem_write, [4:3] reserved.
- `stall` out 1: freezes EX/MEM and earlier stages.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address `{result[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: load data word.
- `wb_valid` out 1: write-back record valid (one-cycle pulse per instruction).
- `wb_pc` out 32, `wb_rd` out 5, `wb_data` out 32, `wb_we` out 1: write-back record fields.
- `misalign` out 1: one-cycle pulse with `wb_valid` on a misaligned access.
- `bus_err` out 1: one-cycle pulse with `wb_valid` on a timeout.

## Operation
- FSM states: IDLE and BUS.
- `stall` = (state == BUS), combinational.
- **IDLE, `in_valid`, neither mem_read nor mem_write:**
  - next cycle: `wb_valid`=1, `wb_data`=`result`, `wb_we`=ctl[0] & (rd != 0).
- **IDLE, `in_valid`, mem op aligned:**
  - latch pc, rd, funct3, addr[1:0], ctl[0], `dmem_we`=ctl[2], `dmem_addr`, `dmem_wdata`, `dmem_be`; enter BUS.
  - mem_write takes priority if both ctl[1] and ctl[2] are set.
- **Alignment:**
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - misaligned: no bus access; next cycle `wb_valid`=1, `misalign`=1, `wb_we`=0, `wb_data`=`result`.
- **Store formatting (lane = addr[1:0]):**
  - SB: wdata = {4{sd[7:0]}}, be = 0001<<lane.
  - SH: wdata = {2{sd[15:0]}}, be = 0011<<lane.
  - SW: wdata = sd, be = 1111.
- **Load byte enables:** same as stores for the access width.
- **BUS:**
  - `dmem_req`=1, and `dmem_addr`/`dmem_we`/`dmem_wdata`/`dmem_be` stay stable until ack.
  - on `dmem_ack`: return to IDLE. Next cycle `wb_valid`=1.
  - load: `wb_data` = formatted rdata, `wb_we`=ctl[0] & (rd != 0).
  - store: `wb_we`=0.
- **Load formatting:**
  - B/BU: byte at lane, sign-/zero-extended.
  - H/HU: half at addr[1], sign-/zero-extended.
  - W: full word.
  - funct3 values 011, 110, 111: treated as W.
- **Timeout:** counter resets on entering BUS. When it reaches `TIMEOUT` without ack: return to IDLE; next cycle `wb_valid`=1, `bus_err`=1, `wb_we`=0.
- `dmem_ack` in IDLE is ignored.
- `in_valid` is ignored while in BUS.
- Upstream holds the next instruction under `stall` and it is accepted in the first IDLE cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset mid-BUS drops `dmem_req` immediately and discards the access with no `wb_valid`.
- Non-memory or misaligned instruction: `wb_valid` 1 cycle after acceptance.
- Memory op accepted in cycle T:
  - `dmem_req` high T+1 through the ack cycle A.
  - `stall` high T+1 through A.
  - `wb_valid` at A+1.
  - next instruction accepted at A+1.
- Minimum memory latency: ack in T+1 gives `wb_valid` at T+2.
- `wb_*` fields hold their last values while `wb_valid`=0. `wb_valid`, `misalign` and `bus_err` are single-cycle pulses.

## Test plan
- ALU op `result`=0x1234, rd=5, ctl=00001 -> 1 cycle later: `wb_valid`=1, `wb_data`=0x1234, `wb_we`=1, `stall` never asserted.
- LB at 0x103, ack after 3 cycles with rdata=0x80AABBCC -> `dmem_addr`=0x100, `dmem_be`=1000; `stall` high 3 cycles; then `wb_data`=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH at 0x202, `store_data`=0xDEADBEEF, ack immediately -> `dmem_we`=1, `dmem_be`=1100, `dmem_wdata`=0xBEEFBEEF; `wb_we`=0; `wb_valid` at T+2.
- LW at 0x101 -> no `dmem_req`; `misalign`=1 with `wb_valid` next cycle; `wb_we`=0.
- `TIMEOUT`=4, no ack -> `dmem_req` high exactly 4 cycles, then `bus_err`=1 and `stall` released; a later ack is ignored.
- `rst` low during BUS -> `dmem_req`=0 immediately; no `wb_valid`. After release, an LW to rd=0 completes with `wb_we`=0.
